pf_xcvr_apblink_arb: RTL and testbench

//  Multi-requester arbiter and serialiser for the transceiver APB link sideband.
//  NUM_CH control-side requesters share one nibble-wide link; a round-robin pick grants one.

---
 rtl/pf_xcvr_apblink_arb.sv | 179 +++++++++++++++++
 tb/tb_pf_xcvr_apblink_arb.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_xcvr_apblink_arb.sv
// Round-robin arbiter and nibble serialiser for the shared XCVR APB link sideband.
// Each grant sends a header beat plus DATA_W/4 data nibbles; read nibbles are gathered into RDATA.
module pf_xcvr_apblink_arb #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                     CTRL_CLK,
    input  logic                     ARST,
    input  logic [NUM_CH-1:0]        REQ,
    input  logic [NUM_CH-1:0]        WE,
    input  logic [3*NUM_CH-1:0]      ADDR,
    input  logic [DATA_W*NUM_CH-1:0] WDATA,
    output logic [NUM_CH-1:0]        GRANT,
    output logic [NUM_CH-1:0]        DONE,
    output logic [DATA_W-1:0]        RDATA,
    output logic                     LINK_CLK,
    output logic [2:0]               LINK_ADDR,
    output logic                     LINK_EN,
    output logic                     LINK_ARST_N,
    output logic [3:0]               LINK_WDATA,
    input  logic [3:0]               LINK_RDATA
);

    localparam int unsigned BEATS = DATA_W / 4;
    localparam int unsigned BW    = $clog2(BEATS + 1);
    localparam int unsigned PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StXfer, StTurn} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       div_q;
    logic                link_clk_q;
    logic [1:0]          arst_sync_q;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                en_q, en_d;
    logic [2:0]          addr_q, addr_d;
    logic [3:0]          lwdata_q, lwdata_d;

    logic                wrap, fall_tick, rise_tick;
    logic                found;
    logic [PW-1:0]       win;

    assign wrap      = (div_q == CW'(CLK_DIV - 1));
    assign fall_tick = wrap & link_clk_q;
    assign rise_tick = wrap & ~link_clk_q;

    always_ff @(posedge CTRL_CLK or posedge ARST) begin
        if (ARST) begin
            div_q      <= '0;
            link_clk_q <= 1'b0;
        end else if (wrap) begin
            div_q      <= '0;
            link_clk_q <= ~link_clk_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge CTRL_CLK or posedge ARST) begin
        if (ARST) begin
            arst_sync_q <= 2'b00;
        end else begin
            arst_sync_q <= {arst_sync_q[0], 1'b1};
        end
    end

    // First requester strictly after the pointer, wrapping.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            if (!found && REQ[(32'(ptr_q) + i) % NUM_CH]) begin
                found = 1'b1;
                win   = PW'((32'(ptr_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        done_d   = '0;
        beat_d   = beat_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        en_d     = en_q;
        addr_d   = addr_q;
        lwdata_d = lwdata_q;

        // Read nibbles arrive LSB first; shifting in from the top leaves them in place at the end.
        if (rise_tick && (state_q == StXfer) && (beat_q != '0) && !we_q) begin
            rdata_d = (rdata_q >> 4) | (DATA_W'(LINK_RDATA) << (DATA_W - 4));
        end

        if (fall_tick) begin
            unique case (state_q)
                // TURN is the idle link period, so it arbitrates directly on its closing tick.
                StIdle, StTurn: begin
                    state_d = StIdle;
                    if (found) begin
                        state_d      = StXfer;
                        ptr_d        = win;
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        we_d         = WE[win];
                        wdata_d      = WDATA[DATA_W*win +: DATA_W];
                        rdata_d      = '0;
                        beat_d       = '0;
                        en_d         = 1'b1;
                        addr_d       = ADDR[3*win +: 3];
                        lwdata_d     = {WE[win], 3'b000};
                    end
                end
                StXfer: begin
                    if (beat_q == BW'(BEATS)) begin
                        state_d  = StTurn;
                        en_d     = 1'b0;
                        lwdata_d = '0;
                        done_d   = grant_q;
                        grant_d  = '0;
                    end else begin
                        beat_d   = beat_q + 1'b1;
                        lwdata_d = wdata_q[3:0];
                        wdata_d  = wdata_q >> 4;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CTRL_CLK or posedge ARST) begin
        if (ARST) begin
            state_q  <= StIdle;
            ptr_q    <= PW'(NUM_CH - 1);
            grant_q  <= '0;
            done_q   <= '0;
            beat_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            lwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            beat_q   <= beat_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            lwdata_q <= lwdata_d;
        end
    end

    assign GRANT       = grant_q;
    assign DONE        = done_q;
    assign RDATA       = (|done_q) ? rdata_q : '0;
    assign LINK_CLK    = link_clk_q;
    assign LINK_ADDR   = addr_q;
    assign LINK_EN     = en_q;
    assign LINK_ARST_N = arst_sync_q[1];
    assign LINK_WDATA  = lwdata_q;

endmodule

// File: tb/tb_pf_xcvr_apblink_arb.sv
// Bench for pf_xcvr_apblink_arb: transaction-level model of round-robin order, link beats and timing.
// Main instance uses 4 channels/16 bits/div 2; two extra instances cover other parameter corners.
module tb_pf_xcvr_apblink_arb;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int CD    = 2;
    localparam int BEATS = DW / 4;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // main instance
    logic [NCH-1:0]    req, we, grant, done;
    logic [3*NCH-1:0]  addr;
    logic [DW*NCH-1:0] wdata;
    logic [DW-1:0]     rdata;
    logic              lclk, len, larst_n;
    logic [2:0]        laddr;
    logic [3:0]        lwdata, lrdata;

    pf_xcvr_apblink_arb #(.NUM_CH(NCH), .DATA_W(DW), .CLK_DIV(CD)) dut (
        .CTRL_CLK(clk), .ARST(arst), .REQ(req), .WE(we), .ADDR(addr), .WDATA(wdata),
        .GRANT(grant), .DONE(done), .RDATA(rdata), .LINK_CLK(lclk), .LINK_ADDR(laddr),
        .LINK_EN(len), .LINK_ARST_N(larst_n), .LINK_WDATA(lwdata), .LINK_RDATA(lrdata));

    // sweep instance A: 1 channel, 4-bit payload, div 1
    logic       req_a, we_a, grant_a, done_a, lclk_a, len_a, larst_n_a;
    logic [2:0] addr_a, laddr_a;
    logic [3:0] wdata_a, rdata_a, lwdata_a, lrdata_a;

    pf_xcvr_apblink_arb #(.NUM_CH(1), .DATA_W(4), .CLK_DIV(1)) dut_a (
        .CTRL_CLK(clk), .ARST(arst), .REQ(req_a), .WE(we_a), .ADDR(addr_a), .WDATA(wdata_a),
        .GRANT(grant_a), .DONE(done_a), .RDATA(rdata_a), .LINK_CLK(lclk_a), .LINK_ADDR(laddr_a),
        .LINK_EN(len_a), .LINK_ARST_N(larst_n_a), .LINK_WDATA(lwdata_a), .LINK_RDATA(lrdata_a));

    // sweep instance B: 2 channels, 32-bit payload, div 3
    logic [1:0]  req_b, we_b, grant_b, done_b;
    logic [5:0]  addr_b;
    logic [63:0] wdata_b;
    logic [31:0] rdata_b;
    logic        lclk_b, len_b, larst_n_b;
    logic [2:0]  laddr_b;
    logic [3:0]  lwdata_b, lrdata_b;

    pf_xcvr_apblink_arb #(.NUM_CH(2), .DATA_W(32), .CLK_DIV(3)) dut_b (
        .CTRL_CLK(clk), .ARST(arst), .REQ(req_b), .WE(we_b), .ADDR(addr_b), .WDATA(wdata_b),
        .GRANT(grant_b), .DONE(done_b), .RDATA(rdata_b), .LINK_CLK(lclk_b), .LINK_ADDR(laddr_b),
        .LINK_EN(len_b), .LINK_ARST_N(larst_n_b), .LINK_WDATA(lwdata_b), .LINK_RDATA(lrdata_b));

    // reference model state: last granted channel
    int rr_last;

    // observation record of one transfer on the main instance
    int               obs_ch, obs_gcyc, obs_dcyc, obs_beats, obs_done_len;
    bit               obs_timeout, obs_onehot, obs_addr_bad;
    logic [3:0]       obs_nib [0:15];
    logic [DW-1:0]    obs_rdata;
    logic [NCH-1:0]   obs_done_vec;
    logic [3:0]       rd_nib [0:15];
    logic [NCH-1:0]   ev_grant_clr, ev_grant_set, ev_done_set;
    bit               scramble;
    logic [2:0]       exp_addr;

    function automatic int rr_pick(input logic [NCH-1:0] pend, input int last);
        for (int i = 1; i <= NCH; i++) begin
            int c;
            c = (last + i) % NCH;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_ch(input int c, input logic w, input logic [2:0] a, input logic [DW-1:0] d);
        we[c]            = w;
        addr[3*c +: 3]   = a;
        wdata[DW*c +: DW] = d;
    endtask

    // Records one transfer: grant, link beats, DONE; serves LINK_RDATA from rd_nib[beat].
    task automatic observe(input int budget);
        logic prev_lclk;
        int   falls, n;
        bit   got_g, got_d;
        got_g = 0; got_d = 0; falls = 0; n = 0;
        obs_ch = -1; obs_beats = 0; obs_done_len = 0; obs_timeout = 0;
        obs_onehot = 0; obs_addr_bad = 0; obs_rdata = '0; obs_done_vec = '0;
        obs_gcyc = 0; obs_dcyc = 0;
        for (int k = 0; k < 16; k++) obs_nib[k] = 4'hx;
        prev_lclk = lclk;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (!got_g && |grant) begin
                got_g      = 1;
                obs_gcyc   = cyc;
                obs_onehot = $onehot(grant);
                for (int c = 0; c < NCH; c++) if (grant[c]) obs_ch = c;
                req = (req & ~ev_grant_clr) | ev_grant_set;
                if (scramble)
                    for (int c = 0; c < NCH; c++)
                        set_ch(c, 1'($urandom), 3'($urandom), DW'($urandom));
            end
            if (got_g && !got_d) begin
                if (prev_lclk && !lclk && len) begin
                    lrdata = rd_nib[falls];
                    falls++;
                end
                if (!prev_lclk && lclk && len) begin
                    if (obs_beats < 16) obs_nib[obs_beats] = lwdata;
                    if (laddr !== exp_addr) obs_addr_bad = 1;
                    obs_beats++;
                end
            end
            if (|done) begin
                if (!got_d) begin
                    got_d        = 1;
                    obs_dcyc     = cyc;
                    obs_rdata    = rdata;
                    obs_done_vec = done;
                    req          = req | ev_done_set;
                end
                obs_done_len++;
            end else if (got_d) begin
                break;
            end
            prev_lclk = lclk;
            if (n >= budget) begin
                obs_timeout = 1;
                break;
            end
        end
        ev_grant_clr = '0; ev_grant_set = '0; ev_done_set = '0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        req  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) arst = 1'b0;
        repeat (2) @(posedge clk);
        rr_last = NCH - 1;
    endtask

    task automatic test_reset();
        int  n, exp_ch;
        bit  seen, bad;
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if ({grant, done, rdata, lclk, laddr, len, larst_n, lwdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {grant, done, rdata, lclk, laddr, len, larst_n, lwdata});
        end
        @(negedge clk) arst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (larst_n !== 1'b0) begin n_fail++; $display("FAIL arst_n_1cyc: got %b want 0", larst_n); end
        @(posedge clk); #1;
        n_cmp++;
        if (larst_n !== 1'b1) begin n_fail++; $display("FAIL arst_n_2cyc: got %b want 1", larst_n); end

        // abort a transfer during its header beat
        set_ch(0, 1'b1, 3'd3, DW'($urandom));
        req = 4'b0001;
        seen = 0; n = 0;
        while (!seen && n < 4 * CD + 2) begin
            @(posedge clk); #1;
            n++;
            seen = grant[0] && len;
        end
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL pre_reset_grant: got %b want 1", seen); end
        #2 arst = 1'b1;
        #1;
        n_cmp++;
        if (len !== 1'b0) begin n_fail++; $display("FAIL reset_link_en: got %b want 0", len); end
        n_cmp++;
        if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
        n_cmp++;
        if (larst_n !== 1'b0) begin n_fail++; $display("FAIL reset_link_arst: got %b want 0", larst_n); end
        req = 4'b0011;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== '0 || len !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin n_fail++; $display("FAIL reset_hold_quiet: got %b want 0", bad); end
        @(negedge clk) arst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (larst_n !== 1'b0) begin n_fail++; $display("FAIL rel_arst_n_1cyc: got %b want 0", larst_n); end
        @(posedge clk); #1;
        n_cmp++;
        if (larst_n !== 1'b1) begin n_fail++; $display("FAIL rel_arst_n_2cyc: got %b want 1", larst_n); end

        // pointer must be back at its reset value: ch0 beats ch1
        rr_last = NCH - 1;
        exp_ch = rr_pick(req, rr_last);
        exp_addr = 3'd3;
        observe(80);
        req = '0;
        n_cmp++;
        if (obs_timeout || obs_ch != exp_ch || exp_ch != 0) begin
            n_fail++;
            $display("FAIL reset_ptr_grant: got ch %0d (timeout %0d) want %0d", obs_ch, obs_timeout, 0);
        end
        n_cmp++;
        if (obs_dcyc - obs_gcyc != (BEATS + 1) * 2 * CD) begin
            n_fail++;
            $display("FAIL reset_fresh_xfer: got %0d want %0d", obs_dcyc - obs_gcyc, (BEATS + 1) * 2 * CD);
        end
        rr_last = exp_ch;
    endtask

    task automatic test_single_write();
        logic [4*(BEATS+1)-1:0] got_seq;
        set_ch(2, 1'b1, 3'd5, 16'hA5C3);
        req = 4'b0100;
        exp_addr = 3'd5;
        observe(80);
        req = '0;
        got_seq = '0;
        for (int k = 0; k <= BEATS; k++) got_seq[4*k +: 4] = obs_nib[k];
        n_cmp++;
        if (obs_timeout || obs_ch != 2) begin
            n_fail++; $display("FAIL wr_grant: got ch %0d (timeout %0d) want 2", obs_ch, obs_timeout);
        end
        n_cmp++;
        if (got_seq !== 20'hA5C38) begin n_fail++; $display("FAIL wr_nibbles: got %h want a5c38", got_seq); end
        n_cmp++;
        if (obs_beats != 5 || obs_addr_bad) begin
            n_fail++; $display("FAIL wr_beats_addr: got %0d beats addr_bad %0d want 5/0", obs_beats, obs_addr_bad);
        end
        n_cmp++;
        if (obs_dcyc - obs_gcyc != 20) begin
            n_fail++; $display("FAIL wr_latency: got %0d want 20", obs_dcyc - obs_gcyc);
        end
        n_cmp++;
        if (obs_done_vec !== 4'b0100 || obs_done_len != 1 || obs_rdata !== '0) begin
            n_fail++;
            $display("FAIL wr_done: got %b len %0d rdata %h want 0100 1 0000",
                     obs_done_vec, obs_done_len, obs_rdata);
        end
        rr_last = 2;
    endtask

    task automatic test_single_read();
        set_ch(0, 1'b0, 3'd1, 16'hFFFF);
        rd_nib[0] = 4'hF; rd_nib[1] = 4'h4; rd_nib[2] = 4'h3; rd_nib[3] = 4'h2; rd_nib[4] = 4'h1;
        req = 4'b0001;
        exp_addr = 3'd1;
        observe(80);
        req = '0;
        n_cmp++;
        if (obs_timeout || obs_ch != 0) begin
            n_fail++; $display("FAIL rd_grant: got ch %0d (timeout %0d) want 0", obs_ch, obs_timeout);
        end
        n_cmp++;
        if (obs_nib[0] !== 4'h0) begin n_fail++; $display("FAIL rd_header: got %h want 0", obs_nib[0]); end
        n_cmp++;
        if (obs_rdata !== 16'h1234 || obs_done_vec !== 4'b0001) begin
            n_fail++; $display("FAIL rd_data: got %h done %b want 1234 0001", obs_rdata, obs_done_vec);
        end
        n_cmp++;
        if (rdata !== '0) begin n_fail++; $display("FAIL rd_after_done: got %h want 0", rdata); end
        rr_last = 0;
    endtask

    task automatic test_fairness();
        int prev_done, exp_ch;
        do_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'($urandom), 3'(c), DW'($urandom));
        req = 4'b1111;
        prev_done = 0;
        for (int t = 0; t < 8; t++) begin
            exp_ch = rr_pick(req, rr_last);
            exp_addr = 3'(exp_ch);
            observe(80);
            n_cmp++;
            if (obs_timeout || obs_ch != exp_ch || exp_ch != t % NCH) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got ch %0d want %0d", t, obs_ch, t % NCH);
            end
            n_cmp++;
            if (!obs_onehot || obs_done_vec !== NCH'(1 << exp_ch)) begin
                n_fail++; $display("FAIL fair_done[%0d]: got %b want ch %0d", t, obs_done_vec, exp_ch);
            end
            if (t > 0) begin
                n_cmp++;
                if (obs_gcyc - prev_done != 2 * CD) begin
                    n_fail++;
                    $display("FAIL fair_gap[%0d]: got %0d want %0d", t, obs_gcyc - prev_done, 2 * CD);
                end
            end
            prev_done = obs_dcyc;
            rr_last = exp_ch;
        end
        req = '0;
    endtask

    task automatic test_drop_rerequest();
        int exp_ch;
        set_ch(1, 1'b1, 3'd6, DW'($urandom));
        set_ch(3, 1'b0, 3'd2, DW'($urandom));
        req = 4'b0010;
        ev_grant_clr = 4'b0010;
        ev_grant_set = 4'b1000;
        ev_done_set  = 4'b0010;
        exp_addr = 3'd6;
        observe(80);
        n_cmp++;
        if (obs_timeout || obs_ch != 1 || obs_done_vec !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_done: got ch %0d done %b want 1 0010", obs_ch, obs_done_vec);
        end
        rr_last = 1;
        for (int t = 0; t < 2; t++) begin
            exp_ch = rr_pick(req, rr_last);
            ev_grant_clr = NCH'(1 << exp_ch);
            exp_addr = (exp_ch == 3) ? 3'd2 : 3'd6;
            observe(80);
            n_cmp++;
            if (obs_timeout || obs_ch != exp_ch || exp_ch != ((t == 0) ? 3 : 1)) begin
                n_fail++;
                $display("FAIL rereq_order[%0d]: got ch %0d want %0d", t, obs_ch, (t == 0) ? 3 : 1);
            end
            rr_last = exp_ch;
        end
        req = '0;
    endtask

    task automatic test_random();
        int exp_ch;
        logic ew;
        logic [DW-1:0] ed, er;
        logic [4*(BEATS+1)-1:0] exp_seq, got_seq;
        for (int t = 0; t < 12; t++) begin
            if (req == '0) req = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int c = 0; c < NCH; c++) set_ch(c, 1'($urandom), 3'($urandom), DW'($urandom));
            for (int k = 0; k <= BEATS; k++) rd_nib[k] = 4'($urandom);
            exp_ch   = rr_pick(req, rr_last);
            ew       = we[exp_ch];
            ed       = wdata[DW*exp_ch +: DW];
            exp_addr = addr[3*exp_ch +: 3];
            er       = '0;
            if (!ew) for (int k = 1; k <= BEATS; k++) er = er | (DW'(rd_nib[k]) << (4 * (k - 1)));
            exp_seq = '0;
            exp_seq[3:0] = ew ? 4'h8 : 4'h0;
            for (int k = 1; k <= BEATS; k++) exp_seq[4*k +: 4] = 4'(ed >> (4 * (k - 1)));
            scramble = 1;
            observe(80);
            scramble = 0;
            got_seq = '0;
            for (int k = 0; k <= BEATS; k++) got_seq[4*k +: 4] = obs_nib[k];
            n_cmp++;
            if (obs_timeout || obs_ch != exp_ch) begin
                n_fail++; $display("FAIL rnd_grant[%0d]: got ch %0d want %0d", t, obs_ch, exp_ch);
            end
            n_cmp++;
            if (got_seq !== exp_seq || obs_addr_bad) begin
                n_fail++;
                $display("FAIL rnd_beats[%0d]: got %h addr_bad %0d want %h", t, got_seq, obs_addr_bad, exp_seq);
            end
            n_cmp++;
            if (obs_rdata !== er || obs_dcyc - obs_gcyc != (BEATS + 1) * 2 * CD) begin
                n_fail++;
                $display("FAIL rnd_done[%0d]: got %h lat %0d want %h lat %0d", t, obs_rdata,
                         obs_dcyc - obs_gcyc, er, (BEATS + 1) * 2 * CD);
            end
            rr_last = exp_ch;
            if (exp_ch >= 0) req[exp_ch] = 1'b0;
            req = req | NCH'($urandom & $urandom);
        end
        req = '0;
    endtask

    task automatic test_param_sweep();
        int   n, ntr, beats, gcyc;
        logic pl, pg;
        logic [3:0]  da;
        logic [7:0]  seq_a;
        logic [31:0] db;
        logic [35:0] seq_b;
        // A: single channel held high must be re-granted every time
        da = 4'($urandom); we_a = 1'b1; addr_a = 3'($urandom); wdata_a = da; req_a = 1'b1;
        ntr = 0; n = 0; beats = 0; gcyc = 0; seq_a = '0; pl = lclk_a; pg = 1'b0;
        while (ntr < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (grant_a && !pg) begin gcyc = cyc; beats = 0; seq_a = '0; end
            if (!pl && lclk_a && len_a) begin
                if (beats < 2) seq_a[4*beats +: 4] = lwdata_a;
                beats++;
            end
            if (done_a) begin
                ntr++;
                n_cmp++;
                if (cyc - gcyc != 4 || beats != 2 || seq_a !== {da, 4'h8} || rdata_a !== '0) begin
                    n_fail++;
                    $display("FAIL sweep_a[%0d]: got lat %0d beats %0d seq %h want 4 2 %h", ntr, cyc - gcyc,
                             beats, seq_a, {da, 4'h8});
                end
            end
            pg = grant_a; pl = lclk_a;
        end
        req_a = 1'b0;
        n_cmp++;
        if (ntr != 2) begin n_fail++; $display("FAIL sweep_a_count: got %0d want 2", ntr); end

        // B: 32-bit write on ch1 at div 3
        db = $urandom; we_b = 2'b10; addr_b = {3'($urandom), 3'd0}; wdata_b = {db, 32'h0};
        lrdata_b = 4'hF; req_b = 2'b10;
        ntr = 0; n = 0; beats = 0; gcyc = 0; seq_b = '0; pl = lclk_b; pg = 1'b0;
        while (ntr < 1 && n < 120) begin
            @(posedge clk); #1;
            n++;
            if (|grant_b && !pg) begin
                gcyc = cyc;
                n_cmp++;
                if (grant_b !== 2'b10) begin n_fail++; $display("FAIL sweep_b_grant: got %b want 10", grant_b); end
            end
            if (!pl && lclk_b && len_b) begin
                if (beats < 9) seq_b[4*beats +: 4] = lwdata_b;
                beats++;
            end
            if (|done_b) begin
                ntr++;
                req_b = 2'b00;
                n_cmp++;
                if (cyc - gcyc != 54 || beats != 9 || seq_b !== {db, 4'h8}) begin
                    n_fail++;
                    $display("FAIL sweep_b_xfer: got lat %0d beats %0d seq %h want 54 9 %h", cyc - gcyc,
                             beats, seq_b, {db, 4'h8});
                end
                n_cmp++;
                if (done_b !== 2'b10 || rdata_b !== '0) begin
                    n_fail++; $display("FAIL sweep_b_done: got %b rdata %h want 10 0", done_b, rdata_b);
                end
            end
            pg = |grant_b; pl = lclk_b;
        end
        req_b = 2'b00;
        n_cmp++;
        if (ntr != 1) begin n_fail++; $display("FAIL sweep_b_count: got %0d want 1", ntr); end
    endtask

    initial begin
        arst = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0; lrdata = '0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; lrdata_a = 4'h5;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; lrdata_b = '0;
        ev_grant_clr = '0; ev_grant_set = '0; ev_done_set = '0;
        scramble = 0; exp_addr = '0; rr_last = NCH - 1;
        for (int k = 0; k < 16; k++) rd_nib[k] = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_fairness();
        test_drop_rerequest();
        test_random();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
